// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared float field layout, bias and FSM state type
//
// Purpose: constants and types shared by the FPU conversion stages.
// Ports:   none (package).
// Config:  INT_TO_FLOAT_ROUND_NEAREST_EN selects rounding in float_round.

package fpu_pkg;

  localparam int FLOAT_EXP_BIAS = 127;
  localparam int EXP_W          = 8;
  localparam int FRAC_W         = 23;
  localparam int INT_W          = 32;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  // Exponent of a magnitude whose leading one sits in bit 31.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FLOAT_EXP_BIAS + INT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } i2f_state_e;

endpackage

// File: rtl/int_to_float_seq_if.sv
// rtl/int_to_float_seq_if.sv - operand/result handshake bundle
//
// Purpose: groups the operand and result valid/ready handshakes.
// Signals: in_valid/in_ready/in_op   operand handshake (master -> slave)
//          out_valid/out_ready/out_res result handshake (slave -> master)
//          busy                        converter not idle
// Config:  none.

interface int_to_float_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        busy;

  modport master (
    output in_valid,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_res,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_res,
    output busy
  );
endinterface

// File: rtl/float_round.sv
// rtl/float_round.sv - mantissa rounding and IEEE-754 single packing
//
// Purpose: turns a normalized magnitude into a packed single.
// Ports:   sign_i   result sign
//          exp_i    biased exponent before rounding carry
//          mag_i    normalized magnitude below the hidden one (mag[30:0])
//          res_o    packed {sign, exp, fraction}
// Config:  INT_TO_FLOAT_ROUND_NEAREST_EN defined -> round to nearest even,
//          undefined -> truncate toward zero.

module float_round
  import fpu_pkg::*;
(
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [30:0]      mag_i,
  output logic [31:0]      res_o
);

`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
  localparam logic ROUND_NE = 1'b1;
`else
  localparam logic ROUND_NE = 1'b0;
`endif

  logic [FRAC_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              round_up;
  logic [FRAC_W:0]   mant_inc;
  logic [EXP_W-1:0]  exp_adj;

  always_comb begin
    mant     = mag_i[30:8];
    guard    = mag_i[7];
    sticky   = |mag_i[6:0];
    lsb      = mag_i[8];
    round_up = ROUND_NE & guard & (sticky | lsb);
    // A carry out of the fraction leaves the low bits zero and bumps exp.
    mant_inc = {1'b0, mant} + {{FRAC_W{1'b0}}, round_up};
    exp_adj  = exp_i + {{(EXP_W-1){1'b0}}, mant_inc[FRAC_W]};
    res_o    = {sign_i, exp_adj, mant_inc[FRAC_W-1:0]};
  end

endmodule

// File: rtl/int_to_float_seq.sv
// rtl/int_to_float_seq.sv - iterative signed int32 to IEEE-754 single converter
//
// Purpose: accepts a two's-complement operand, normalizes it by 8-bit then
//          1-bit left shifts, rounds once and holds the result until taken.
// Ports:   clock    rising-edge clock
//          reset_n  asynchronous active-low reset
//          bus      int_to_float_seq_if.slave (operand/result handshakes, busy)
// Config:  INT_TO_FLOAT_ROUND_NEAREST_EN (see float_round).

module int_to_float_seq
  import fpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  int_to_float_seq_if.slave bus
);

  i2f_state_e       state_q;
  logic             sign_q;
  logic [31:0]      mag_q;
  logic [EXP_W-1:0] exp_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      out_res_q;
  logic             busy_q;

  logic [31:0]      mag_d;
  logic [31:0]      round_res;

  // |in_op|; 0x80000000 negates to itself, which is the correct magnitude.
  assign mag_d = bus.in_op[31] ? (~bus.in_op + 32'd1) : bus.in_op;

  float_round u_round (
    .sign_i (sign_q),
    .exp_i  (exp_q),
    .mag_i  (mag_q[30:0]),
    .res_o  (round_res)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= EXP_INIT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_res_q   <= FLOAT_ZERO;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_q     <= bus.in_op[31];
            mag_q      <= mag_d;
            exp_q      <= EXP_INIT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // Zero skips normalization; ROUND emits the canonical zero so
            // the result appears one edge after accept.
            state_q    <= (bus.in_op == 32'd0) ? ST_ROUND : ST_NORM;
          end
        end
        ST_NORM: begin
          if (mag_q[31:24] == 8'd0) begin
            mag_q <= mag_q << 8;
            exp_q <= exp_q - EXP_W'(8);
          end else if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end else begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          // Only a zero operand reaches ROUND without a leading one.
          out_res_q   <= mag_q[31] ? round_res : FLOAT_ZERO;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.busy      = busy_q;

endmodule
